rbt_s_parser_input_arbiter: RTL and testbench
=============================================

# rbt_s_parser_input_arbiter

Round-robin arbiter that shares one transport-layer parser chain between `PORT_NUM` header sources, e.g. per-MAC header extractors. It sits in front of the first parser stage. Each cycle it grants at most one source, registers that source's header, length and PHV into a single output slot, and tags the slot with the source port index. A per-port enable mask lets the control plane take a source out of arbitration without touching the datapath.

## Interface
Parameters:
- `HEADER_WIDTH`, 2048: header bus width in bits; must be a multiple of 8.
- `PHV_WIDTH`, 408: PHV width in bits.
- `PORT_NUM`, 4: number of requesters; legal range 2..16.
- `PORT_ID_WIDTH`, 2: width of the port tag; must be at least clog2(`PORT_NUM`).

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: asynchronous, active-high reset.
- `in_port_en`  in  `PORT_NUM`: per-port enable; bit i = 0 excludes port i from arbitration.
- `in_proto_hdr_valid`  in  `PORT_NUM`: per-port valid.
- `in_proto_hdr_ready`  out  `PORT_NUM`: per-port ready.
- `in_proto_hdr_length`  in  16·`PORT_NUM`: lengths, port i at bits [16i +: 16].
- `in_proto_hdr_data`  in  `HEADER_WIDTH`·`PORT_NUM`: headers, port i at [`HEADER_WIDTH`·i +: `HEADER_WIDTH`].
- `in_proto_hdr_phv`  in  `PHV_WIDTH`·`PORT_NUM`: PHVs, port i at [`PHV_WIDTH`·i +: `PHV_WIDTH`].
- `out_proto_hdr_valid`  out  1: output slot occupied.
- `out_proto_hdr_ready`  in  1: downstream parser accepts.
- `out_proto_hdr_data`  out  `HEADER_WIDTH`: granted header.
- `out_proto_hdr_phv`  out  `PHV_WIDTH`: granted PHV.
- `out_proto_hdr_length`  out  16: granted length.
- `out_proto_hdr_port`  out  `PORT_ID_WIDTH`: index of the source port.

## Operation
- Eligible request vector: `req = in_proto_hdr_valid & in_port_en`.
- Slot free condition: `load_ok = !out_proto_hdr_valid || out_proto_hdr_ready`.
- Grant selection:
  - The grant is one-hot and combinational: the first set bit of `req`, scanning upward from `rr_ptr` and wrapping at `PORT_NUM-1` → 0.
  - `in_proto_hdr_ready[i] = grant[i] & load_ok`. At most one ready is high per cycle.
  - Disabled ports always see ready = 0.
- Transfer: when `|grant & load_ok`, the slot loads the granted port's data, PHV and length, and sets port = index and valid = 1.
- Pointer update: `rr_ptr` becomes (granted index + 1) mod `PORT_NUM`, on a transfer only. No request, or a stalled output, leaves `rr_ptr` unchanged.
- Output drain: if `out_proto_hdr_valid & out_proto_hdr_ready` and nothing is loaded that cycle, valid clears.
- Simultaneous drain and load: load wins, valid stays 1, and the new contents appear on the next cycle.
- Content retention: data, PHV and length registers are not modified on drain. They hold their last value until the next load.
- Header contents are never inspected or modified. PHV passes through bit-exact.
- Mask changes:
  - A change to `in_port_en` takes effect in the same cycle's arbitration.
  - A header already in the slot is unaffected.
  - Deasserting the enable of a port whose valid is high leaves that port stalled. The upstream must hold its valid/data per the valid/ready rule.
- Fairness: with all ports requesting continuously and ready = 1, grants rotate 0,1,…,`PORT_NUM-1`,0. Worst-case wait for an enabled requester is `PORT_NUM-1` transfers.

## Timing
- Latency is 1 cycle from accepted input handshake to `out_proto_hdr_valid`.
- Throughput is 1 header per cycle while `out_proto_hdr_ready` = 1.
- Stall (valid = 1, ready = 0):
  - All `in_proto_hdr_ready` are 0.
  - The slot holds all outputs stable.
- Reset (asynchronous, active-high):
  - Outputs clear immediately: `out_proto_hdr_valid` = 0, data = 0, PHV = 0, length = 0, port = 0.
  - `rr_ptr` = 0.
  - `in_proto_hdr_ready` = 0, because `rst` gates the grant.
- Reset mid-operation: a header in the slot is discarded without being presented. Upstream sources keep valid held and are re-arbitrated after deassertion, starting from port 0.
- No combinational path from `out_proto_hdr_ready` to output data. There is one path from `out_proto_hdr_ready` to `in_proto_hdr_ready`, through `load_ok`.

## Structure
- Shared package `rbt_s_parser_pkg` holds `HEADER_WIDTH`, `PHV_WIDTH` and the PHV B/H/W layout localparams, common to all parser stages.
- Sub-module `rbt_s_rr_arbiter` (`PORT_NUM`, `PORT_ID_WIDTH`) contains:
  - the `req` → one-hot `grant` + `grant_idx` logic;
  - `rr_ptr` with an advance strobe.
- The top level contains the port muxes and the output slot only.

## Test plan
- Reset and single port: assert `rst`, then release it. Port 2 presents length = 64, data = 0xAB…, PHV = 0x5. Required: ready[2] = 1 in the same cycle; one cycle later valid = 1, port = 2, and length, data and PHV match the inputs.
- Rotation: all 4 ports valid and enabled, ready held at 1 for 8 cycles. Required: output ports 0,1,2,3,0,1,2,3; exactly one ready high per cycle.
- Back-pressure: ready = 0 for 5 cycles with the slot full. Required: all input readies 0 and outputs unchanged. Ready = 1 in the 6th cycle: the held header drains and the next grant loads in the same cycle, so valid stays 1.
- Mask: `in_port_en` = 4'b1011, all ports valid. Required: port 2 is never granted; sequence 0,1,3,0,… After setting bit 2 to 1, port 2 is granted within 3 transfers.
- Idle pointer hold: grant port 1, then 3 cycles with no requests, then ports 0 and 3 request. Required: port 3 is granted first (`rr_ptr` = 2), then port 0.
- Asynchronous reset mid-stall: slot full with port 1's header, ready = 0, assert `rst` between clock edges. Required: valid drops before the next edge and all outputs read 0. After release, arbitration restarts from port 0.

Source files
------------

// File: rtl/rbt_s_parser_pkg.sv
// Shared parser-chain constants: bus widths and the PHV container layout.
package rbt_s_parser_pkg;

    // Header bus width in bits (multiple of 8).
    localparam int HEADER_WIDTH = 2048;

    // PHV layout: byte, half-word and word containers followed by metadata.
    localparam int PHV_B_COUNT  = 8;
    localparam int PHV_H_COUNT  = 8;
    localparam int PHV_W_COUNT  = 6;
    localparam int PHV_B_WIDTH  = 8;
    localparam int PHV_H_WIDTH  = 16;
    localparam int PHV_W_WIDTH  = 32;
    localparam int PHV_B_OFFSET = 0;
    localparam int PHV_H_OFFSET = PHV_B_OFFSET + PHV_B_COUNT * PHV_B_WIDTH;
    localparam int PHV_W_OFFSET = PHV_H_OFFSET + PHV_H_COUNT * PHV_H_WIDTH;
    localparam int PHV_MD_OFFSET = PHV_W_OFFSET + PHV_W_COUNT * PHV_W_WIDTH;
    localparam int PHV_MD_WIDTH = 24;
    localparam int PHV_WIDTH    = PHV_MD_OFFSET + PHV_MD_WIDTH;   // 408

    // Default arbitration geometry for the input arbiter.
    localparam int DEFAULT_PORT_NUM      = 4;
    localparam int DEFAULT_PORT_ID_WIDTH = 2;

    // Minimum tag width needed to index n ports.
    function automatic int port_id_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rbt_s_parser_input_arbiter_if.sv
// Bundle of the per-port header inputs and the single arbitrated output slot.
// Handshake: a beat moves on a channel in any cycle where valid and ready are
// both high; a source holding valid must keep its data stable until ready.
interface rbt_s_parser_input_arbiter_if #(
    parameter int HEADER_WIDTH  = rbt_s_parser_pkg::HEADER_WIDTH,
    parameter int PHV_WIDTH     = rbt_s_parser_pkg::PHV_WIDTH,
    parameter int PORT_NUM      = rbt_s_parser_pkg::DEFAULT_PORT_NUM,
    parameter int PORT_ID_WIDTH = rbt_s_parser_pkg::DEFAULT_PORT_ID_WIDTH
);
    logic [PORT_NUM-1:0]              in_port_en;
    logic [PORT_NUM-1:0]              in_proto_hdr_valid;
    logic [PORT_NUM-1:0]              in_proto_hdr_ready;
    logic [16*PORT_NUM-1:0]           in_proto_hdr_length;
    logic [HEADER_WIDTH*PORT_NUM-1:0] in_proto_hdr_data;
    logic [PHV_WIDTH*PORT_NUM-1:0]    in_proto_hdr_phv;

    logic                             out_proto_hdr_valid;
    logic                             out_proto_hdr_ready;
    logic [HEADER_WIDTH-1:0]          out_proto_hdr_data;
    logic [PHV_WIDTH-1:0]             out_proto_hdr_phv;
    logic [15:0]                      out_proto_hdr_length;
    logic [PORT_ID_WIDTH-1:0]         out_proto_hdr_port;

    // Arbiter side.
    modport slave (
        input  in_port_en, in_proto_hdr_valid, in_proto_hdr_length,
               in_proto_hdr_data, in_proto_hdr_phv, out_proto_hdr_ready,
        output in_proto_hdr_ready, out_proto_hdr_valid, out_proto_hdr_data,
               out_proto_hdr_phv, out_proto_hdr_length, out_proto_hdr_port
    );

    // Sources / downstream parser side.
    modport master (
        output in_port_en, in_proto_hdr_valid, in_proto_hdr_length,
               in_proto_hdr_data, in_proto_hdr_phv, out_proto_hdr_ready,
        input  in_proto_hdr_ready, out_proto_hdr_valid, out_proto_hdr_data,
               out_proto_hdr_phv, out_proto_hdr_length, out_proto_hdr_port
    );
endinterface

// File: rtl/rbt_s_rr_arbiter.sv
// Round-robin grant: first request at or above the pointer, wrapping.
// The pointer moves past the winner only when the caller strobes i_advance.
module rbt_s_rr_arbiter #(
    parameter int PORT_NUM      = 4,
    parameter int PORT_ID_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PORT_NUM-1:0]      i_req,
    input  logic                     i_advance,
    output logic [PORT_NUM-1:0]      o_grant,
    output logic [PORT_ID_WIDTH-1:0] o_grant_idx
);
    logic [PORT_ID_WIDTH-1:0] r_rr_ptr;
    logic [2*PORT_NUM-1:0]    w_req_dbl;
    logic [PORT_ID_WIDTH-1:0] w_offset;
    logic                     w_found;
    logic [PORT_ID_WIDTH:0]   w_sum;
    logic [PORT_ID_WIDTH-1:0] w_idx;

    // Rotate the request vector so bit 0 is the pointer position.
    assign w_req_dbl = {i_req, i_req} >> r_rr_ptr;

    // Find the distance from the pointer to the first requester.
    always_comb begin
        w_offset = '0;
        w_found  = 1'b0;
        for (int i = 0; i < PORT_NUM; i++) begin
            if (!w_found && w_req_dbl[i]) begin
                w_found  = 1'b1;
                w_offset = PORT_ID_WIDTH'(i);
            end
        end
    end

    // Map the distance back to an absolute index, wrapping at PORT_NUM; reset gates the grant.
    always_comb begin
        w_sum = {1'b0, r_rr_ptr} + {1'b0, w_offset};
        if (w_sum >= (PORT_ID_WIDTH+1)'(PORT_NUM)) begin
            w_idx = PORT_ID_WIDTH'(w_sum - (PORT_ID_WIDTH+1)'(PORT_NUM));
        end else begin
            w_idx = PORT_ID_WIDTH'(w_sum);
        end
        if (w_found && !rst) begin
            o_grant     = PORT_NUM'(1) << w_idx;
            o_grant_idx = w_idx;
        end else begin
            o_grant     = '0;
            o_grant_idx = '0;
        end
    end

    // Advance the pointer to one past the granted port on a transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (i_advance) begin
            if (o_grant_idx == PORT_ID_WIDTH'(PORT_NUM - 1)) begin
                r_rr_ptr <= '0;
            end else begin
                r_rr_ptr <= o_grant_idx + 1'b1;
            end
        end
    end
endmodule

// File: rtl/rbt_s_parser_input_arbiter.sv
// Shares one parser chain between PORT_NUM header sources: round-robin
// grant, port muxes and a single registered output slot tagged with the port.
module rbt_s_parser_input_arbiter #(
    parameter int HEADER_WIDTH  = rbt_s_parser_pkg::HEADER_WIDTH,
    parameter int PHV_WIDTH     = rbt_s_parser_pkg::PHV_WIDTH,
    parameter int PORT_NUM      = rbt_s_parser_pkg::DEFAULT_PORT_NUM,
    parameter int PORT_ID_WIDTH = rbt_s_parser_pkg::DEFAULT_PORT_ID_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    rbt_s_parser_input_arbiter_if.slave   bus
);
    import rbt_s_parser_pkg::*;

    logic [PORT_NUM-1:0]      w_req;
    logic                     w_load_ok;
    logic                     w_xfer;
    logic [PORT_NUM-1:0]      w_grant;
    logic [PORT_ID_WIDTH-1:0] w_grant_idx;
    logic [HEADER_WIDTH-1:0]  w_data;
    logic [PHV_WIDTH-1:0]     w_phv;
    logic [15:0]              w_len;

    logic                     r_valid;
    logic [HEADER_WIDTH-1:0]  r_data;
    logic [PHV_WIDTH-1:0]     r_phv;
    logic [15:0]              r_len;
    logic [PORT_ID_WIDTH-1:0] r_port;

    assign w_req     = bus.in_proto_hdr_valid & bus.in_port_en;
    assign w_load_ok = !r_valid || bus.out_proto_hdr_ready;
    assign w_xfer    = (|w_grant) && w_load_ok;

    rbt_s_rr_arbiter #(
        .PORT_NUM      (PORT_NUM),
        .PORT_ID_WIDTH (PORT_ID_WIDTH)
    ) u_rr_arbiter (
        .clk         (clk),
        .rst         (rst),
        .i_req       (w_req),
        .i_advance   (w_xfer),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    // Only the granted port sees ready, and only when the slot can take it.
    assign bus.in_proto_hdr_ready = w_grant & {PORT_NUM{w_load_ok}};

    // Select the granted port's header, PHV and length (grant is one-hot).
    always_comb begin
        w_data = '0;
        w_phv  = '0;
        w_len  = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            if (w_grant[i]) begin
                w_data = bus.in_proto_hdr_data[i*HEADER_WIDTH +: HEADER_WIDTH];
                w_phv  = bus.in_proto_hdr_phv[i*PHV_WIDTH +: PHV_WIDTH];
                w_len  = bus.in_proto_hdr_length[i*16 +: 16];
            end
        end
    end

    // Output slot: a load beats a drain; contents are kept after a drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_phv   <= '0;
            r_len   <= '0;
            r_port  <= '0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_data;
            r_phv   <= w_phv;
            r_len   <= w_len;
            r_port  <= w_grant_idx;
        end else if (bus.out_proto_hdr_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.out_proto_hdr_valid  = r_valid;
    assign bus.out_proto_hdr_data   = r_data;
    assign bus.out_proto_hdr_phv    = r_phv;
    assign bus.out_proto_hdr_length = r_len;
    assign bus.out_proto_hdr_port   = r_port;
endmodule

// File: tb/tb_rbt_s_parser_input_arbiter.sv
// Bench for the parser input arbiter: vector table of arbitration cases with
// a scoreboard of headers expected in the output slot, plus hand sequences
// for reset behaviour.
module tb_rbt_s_parser_input_arbiter;
    localparam int HW  = rbt_s_parser_pkg::HEADER_WIDTH;
    localparam int PW  = rbt_s_parser_pkg::PHV_WIDTH;
    localparam int PN  = 4;
    localparam int PIW = 2;
    localparam int W   = PIW + 16 + PW + HW;
    localparam int PHV_LO  = HW;
    localparam int LEN_LO  = HW + PW;
    localparam int PORT_LO = HW + PW + 16;

    typedef struct {
        logic [PN-1:0] en;
        logic [PN-1:0] valid;
        logic          oready;
        logic [PN-1:0] exp_ready;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    logic [W-1:0] exp_q[$];
    vec_t vecs[$];

    rbt_s_parser_input_arbiter_if bus ();

    rbt_s_parser_input_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk_eq(input string name, input bit ok,
                          input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        chk_eq(name, got === exp, got, exp);
    endtask

    task automatic randomize_inputs();
        for (int p = 0; p < PN; p++) begin
            for (int w = 0; w < HW/32; w++)
                bus.in_proto_hdr_data[p*HW + w*32 +: 32] = $urandom();
            for (int w = 0; w < 12; w++)
                bus.in_proto_hdr_phv[p*PW + w*32 +: 32] = $urandom();
            bus.in_proto_hdr_phv[p*PW + 384 +: 24] = 24'($urandom());
            bus.in_proto_hdr_length[p*16 +: 16] = 16'($urandom_range(0, 65535));
        end
    endtask

    // Checks the slot against the scoreboard head, then checks readies and
    // records the header expected to load at the coming edge.
    task automatic apply(input logic [PN-1:0] en, input logic [PN-1:0] valid,
                         input logic oready, input logic [PN-1:0] exp_ready,
                         input string tag);
        logic [W-1:0] e;
        bus.in_port_en          = en;
        bus.in_proto_hdr_valid  = valid;
        bus.out_proto_hdr_ready = oready;
        #3;
        chk({tag, ".ready"}, bus.in_proto_hdr_ready, exp_ready);
        if (exp_q.size() == 0) begin
            chk({tag, ".valid_idle"}, bus.out_proto_hdr_valid, 1'b0);
        end else begin
            e = exp_q[0];
            chk({tag, ".valid"}, bus.out_proto_hdr_valid, 1'b1);
            chk({tag, ".port"}, bus.out_proto_hdr_port, e[PORT_LO +: PIW]);
            chk({tag, ".len"}, bus.out_proto_hdr_length, e[LEN_LO +: 16]);
            chk_eq({tag, ".phv(low128)"}, bus.out_proto_hdr_phv === e[PHV_LO +: PW],
                   bus.out_proto_hdr_phv[127:0], e[PHV_LO +: 128]);
            chk_eq({tag, ".data(low128)"}, bus.out_proto_hdr_data === e[HW-1:0],
                   bus.out_proto_hdr_data[127:0], e[127:0]);
            if (oready) void'(exp_q.pop_front());
        end
        for (int i = 0; i < PN; i++) begin
            if (exp_ready[i]) begin
                exp_q.push_back({PIW'(i), bus.in_proto_hdr_length[i*16 +: 16],
                                 bus.in_proto_hdr_phv[i*PW +: PW],
                                 bus.in_proto_hdr_data[i*HW +: HW]});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [PN-1:0] en, input logic [PN-1:0] valid,
                       input logic oready, input logic [PN-1:0] exp_ready);
        vec_t v;
        v.en = en; v.valid = valid; v.oready = oready; v.exp_ready = exp_ready;
        vecs.push_back(v);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, ".valid"}, bus.out_proto_hdr_valid, 1'b0);
        chk({tag, ".port"}, bus.out_proto_hdr_port, '0);
        chk({tag, ".len"}, bus.out_proto_hdr_length, '0);
        chk_eq({tag, ".phv"}, bus.out_proto_hdr_phv === '0, bus.out_proto_hdr_phv[127:0], '0);
        chk_eq({tag, ".data"}, bus.out_proto_hdr_data === '0, bus.out_proto_hdr_data[127:0], '0);
        chk({tag, ".ready"}, bus.in_proto_hdr_ready, '0);
    endtask

    initial begin
        logic [HW-1:0] ab_data;

        // Vector table; pointer starts at 3 after the single-port test.
        add(4'hF, 4'b1000, 1'b1, 4'b1000);                         // align pointer to 0
        for (int k = 0; k < 8; k++) add(4'hF, 4'hF, 1'b1, 4'b0001 << (k % 4)); // rotation
        for (int k = 0; k < 5; k++) add(4'hF, 4'hF, 1'b0, 4'b0000); // back-pressure
        add(4'hF, 4'hF, 1'b1, 4'b0001);                            // drain + load same cycle
        add(4'b1011, 4'hF, 1'b1, 4'b0010);                         // mask: port 2 skipped
        add(4'b1011, 4'hF, 1'b1, 4'b1000);
        add(4'b1011, 4'hF, 1'b1, 4'b0001);
        add(4'b1011, 4'hF, 1'b1, 4'b0010);
        add(4'b1011, 4'hF, 1'b1, 4'b1000);
        add(4'hF, 4'hF, 1'b1, 4'b0001);                            // unmask
        add(4'hF, 4'hF, 1'b1, 4'b0010);
        add(4'hF, 4'hF, 1'b1, 4'b0100);
        add(4'hF, 4'b0010, 1'b1, 4'b0010);                         // idle pointer hold
        for (int k = 0; k < 3; k++) add(4'hF, 4'b0000, 1'b1, 4'b0000);
        add(4'hF, 4'b1001, 1'b1, 4'b1000);
        add(4'hF, 4'b0001, 1'b1, 4'b0001);
        add(4'b1110, 4'b0001, 1'b1, 4'b0000);                      // disabled sole requester
        add(4'hF, 4'b0010, 1'b1, 4'b0010);                         // slot gets port 1
        add(4'hF, 4'b0000, 1'b0, 4'b0000);                         // stall with port 1 held

        // Reset state with all sources requesting.
        bus.in_port_en          = 4'hF;
        bus.in_proto_hdr_valid  = 4'hF;
        bus.out_proto_hdr_ready = 1'b1;
        randomize_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst = 1'b0;

        // Single port after reset: header 0xAB.., length 64, PHV 5 on port 2.
        for (int i = 0; i < HW/8; i++) ab_data[i*8 +: 8] = 8'hAB;
        bus.in_proto_hdr_data[2*HW +: HW]    = ab_data;
        bus.in_proto_hdr_length[2*16 +: 16]  = 16'd64;
        bus.in_proto_hdr_phv[2*PW +: PW]     = PW'(5);
        apply(4'hF, 4'b0100, 1'b1, 4'b0100, "single");

        foreach (vecs[k]) begin
            randomize_inputs();
            apply(vecs[k].en, vecs[k].valid, vecs[k].oready, vecs[k].exp_ready,
                  $sformatf("vec%0d", k));
        end

        // Asynchronous reset between edges while port 1's header is stalled.
        bus.in_proto_hdr_valid  = 4'h0;
        bus.out_proto_hdr_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_outputs_zero("async_rst");
        exp_q.delete();
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Arbitration restarts from port 0.
        randomize_inputs();
        apply(4'hF, 4'hF, 1'b1, 4'b0001, "restart");
        apply(4'hF, 4'h0, 1'b1, 4'b0000, "flush0");
        apply(4'hF, 4'h0, 1'b1, 4'b0000, "flush1");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
